// File: rtl/qsort_pkg.sv
// Shared definitions for the sort-accelerator host driver: FSM encoding,
// accelerator register offsets and ap_ctrl bit positions.
package qsort_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WR_START = 3'd1,
      S_PUSH     = 3'd2,
      S_PULL     = 3'd3,
      S_POLL_AR  = 3'd4,
      S_POLL_R   = 3'd5,
      S_DONE     = 3'd6
   } state_t;

   localparam int ADDR_AP_CTRL  = 'h00;
   localparam int ADDR_AP_START = 'h08;

   localparam int AP_START = 0;
   localparam int AP_DONE  = 1;
   localparam int AP_IDLE  = 2;

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry registered stream stage; payload is held while out_valid is
// high and out_ready is low, and a new beat is taken whenever the slot drains.
module axis_reg_slice #(
   parameter int pDATA_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [pDATA_WIDTH-1:0] in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [pDATA_WIDTH-1:0] out_data,
   output logic                   out_last
);

   logic                   valid_q, valid_d;
   logic                   last_q, last_d;
   logic [pDATA_WIDTH-1:0] data_q, data_d;

   always_comb begin
      in_ready = !valid_q || out_ready;
      valid_d  = valid_q;
      data_d   = data_q;
      last_d   = last_q;
      if (in_ready) begin
         valid_d = in_valid;
         if (in_valid) begin
            data_d = in_data;
            last_d = in_last;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_last  = last_q;

endmodule

// File: rtl/qsort_host.sv
// Host-side driver running one sort job: write ap_start, stream pN_IN words
// out, forward pN_OUT results, then poll ap_ctrl until ap_done or timeout.
//   state      | meaning
//   S_IDLE     | waiting for start
//   S_WR_START | AXI-Lite write of 1 to ap_start
//   S_PUSH     | streaming source words into the accelerator
//   S_PULL     | forwarding result words to the local sink
//   S_POLL_AR  | issuing ap_ctrl read address
//   S_POLL_R   | waiting for ap_ctrl read data
//   S_DONE     | one-cycle done pulse
module qsort_host
   import qsort_pkg::*;
#(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int pN_IN       = 10,
   parameter int pN_OUT      = 2,
   parameter int pPOLL_MAX   = 1024
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   input  logic                   src_valid,
   output logic                   src_ready,
   input  logic [pDATA_WIDTH-1:0] src_data,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [pDATA_WIDTH-1:0] res_data,
   output logic                   awvalid,
   output logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   awready,
   output logic                   wvalid,
   output logic [pDATA_WIDTH-1:0] wdata,
   input  logic                   wready,
   output logic                   arvalid,
   output logic [pADDR_WIDTH-1:0] araddr,
   input  logic                   arready,
   input  logic                   rvalid,
   input  logic [pDATA_WIDTH-1:0] rdata,
   output logic                   rready,
   output logic                   ss_tvalid,
   output logic                   ss_tlast,
   output logic [pDATA_WIDTH-1:0] ss_tdata,
   input  logic                   ss_tready,
   input  logic                   sm_tvalid,
   input  logic                   sm_tlast,
   input  logic [pDATA_WIDTH-1:0] sm_tdata,
   output logic                   sm_tready
);

   localparam int WCW = $clog2(pN_IN) + 1;
   localparam int PCW = $clog2(pPOLL_MAX) + 1;

   state_t                 state_q, state_d;
   logic                   awvalid_q, awvalid_d;
   logic                   wvalid_q, wvalid_d;
   logic                   arvalid_q, arvalid_d;
   logic                   rready_q, rready_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic [pADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [pADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [WCW-1:0]         word_cnt_q, word_cnt_d;
   logic [7:0]             out_cnt_q, out_cnt_d;
   logic [PCW-1:0]         poll_cnt_q, poll_cnt_d;
   logic [PCW-1:0]         poll_nxt;
   logic [7:0]             out_nxt;

   logic push_en, slice_in_ready, slice_in_valid, src_hs, ss_last_hs, sm_hs;
   logic unused_inputs;

   // word_cnt_q holds the words still to be taken from the source
   assign push_en        = (state_q == S_PUSH) && (word_cnt_q != '0);
   assign src_ready      = push_en && slice_in_ready;
   assign slice_in_valid = push_en && src_valid;
   assign src_hs         = src_valid && src_ready;
   assign ss_last_hs     = ss_tvalid && ss_tready && ss_tlast;

   axis_reg_slice #(.pDATA_WIDTH(pDATA_WIDTH)) u_slice (
      .clk       (axis_clk),
      .rst_n     (axis_rst_n),
      .in_valid  (slice_in_valid),
      .in_ready  (slice_in_ready),
      .in_data   (src_data),
      .in_last   (word_cnt_q == WCW'(1)),
      .out_valid (ss_tvalid),
      .out_ready (ss_tready),
      .out_data  (ss_tdata),
      .out_last  (ss_tlast)
   );

   assign res_valid = (state_q == S_PULL) && sm_tvalid;
   assign res_data  = sm_tdata;
   assign sm_tready = (state_q == S_PULL) && res_ready;
   assign sm_hs     = sm_tvalid && sm_tready;

   assign unused_inputs = ^{sm_tlast, rdata};

   always_comb begin
      state_d    = state_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      arvalid_d  = arvalid_q;
      rready_d   = rready_q;
      done_d     = 1'b0;
      err_d      = err_q;
      awaddr_d   = awaddr_q;
      araddr_d   = araddr_q;
      wdata_d    = wdata_q;
      word_cnt_d = word_cnt_q;
      out_cnt_d  = out_cnt_q;
      poll_cnt_d = poll_cnt_q;
      poll_nxt   = poll_cnt_q + 1'b1;
      out_nxt    = out_cnt_q + 8'd1;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_WR_START;
               awvalid_d  = 1'b1;
               wvalid_d   = 1'b1;
               awaddr_d   = pADDR_WIDTH'(ADDR_AP_START);
               wdata_d    = pDATA_WIDTH'(1 << AP_START);
               err_d      = 1'b0;
               word_cnt_d = WCW'(pN_IN);
               out_cnt_d  = '0;
               poll_cnt_d = '0;
            end
         end
         S_WR_START: begin
            if (awready) awvalid_d = 1'b0;
            if (wready)  wvalid_d  = 1'b0;
            if ((!awvalid_q || awready) && (!wvalid_q || wready)) state_d = S_PUSH;
         end
         S_PUSH: begin
            if (src_hs)     word_cnt_d = word_cnt_q - 1'b1;
            if (ss_last_hs) state_d    = S_PULL;
         end
         S_PULL: begin
            if (sm_hs) begin
               out_cnt_d = out_nxt;
               if (out_nxt == 8'(pN_OUT)) begin
                  state_d   = S_POLL_AR;
                  arvalid_d = 1'b1;
                  araddr_d  = pADDR_WIDTH'(ADDR_AP_CTRL);
               end
            end
         end
         S_POLL_AR: begin
            if (arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_POLL_R;
            end
         end
         S_POLL_R: begin
            if (rvalid) begin
               rready_d = 1'b0;
               if (rdata[AP_DONE]) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  poll_cnt_d = poll_nxt;
                  if (poll_nxt == PCW'(pPOLL_MAX)) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                     err_d   = 1'b1;
                  end else begin
                     state_d   = S_POLL_AR;
                     arvalid_d = 1'b1;
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge axis_clk) begin
      if (!axis_rst_n) begin
         state_q    <= S_IDLE;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         awaddr_q   <= '0;
         araddr_q   <= '0;
         wdata_q    <= '0;
         word_cnt_q <= '0;
         out_cnt_q  <= '0;
         poll_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         arvalid_q  <= arvalid_d;
         rready_q   <= rready_d;
         done_q     <= done_d;
         err_q      <= err_d;
         awaddr_q   <= awaddr_d;
         araddr_q   <= araddr_d;
         wdata_q    <= wdata_d;
         word_cnt_q <= word_cnt_d;
         out_cnt_q  <= out_cnt_d;
         poll_cnt_q <= poll_cnt_d;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;
   assign err     = err_q;
   assign awvalid = awvalid_q;
   assign awaddr  = awaddr_q;
   assign wvalid  = wvalid_q;
   assign wdata   = wdata_q;
   assign arvalid = arvalid_q;
   assign araddr  = araddr_q;
   assign rready  = rready_q;

endmodule

// File: tb/tb_qsort_host.sv
// Bench for qsort_host: behavioural accelerator (AXI-Lite slave, stream sink
// that sorts, result source) with a table of job configurations.
module tb_qsort_host;

   localparam int AW = 12, DW = 32, N_IN = 10, N_OUT = 2, POLL_MAX = 4;

   typedef logic [DW-1:0] warr_t [N_IN];

   typedef struct {
      int            aw_wait;
      int            w_wait;
      bit            ss_rand;
      bit            src_rand;
      int            res_hold;
      logic [DW-1:0] status;
      int            exp_polls;
      bit            exp_err;
      bit            exp_split;
   } job_t;

   logic axis_clk = 1'b0;
   always #5 axis_clk = ~axis_clk;

   logic          axis_rst_n, start, busy, done, err;
   logic          src_valid, src_ready, res_valid, res_ready;
   logic [DW-1:0] src_data, res_data;
   logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
   logic [AW-1:0] awaddr, araddr;
   logic [DW-1:0] wdata, rdata;
   logic          ss_tvalid, ss_tlast, ss_tready;
   logic [DW-1:0] ss_tdata;
   logic          sm_tvalid, sm_tlast, sm_tready;
   logic [DW-1:0] sm_tdata;

   qsort_host #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pN_IN(N_IN), .pN_OUT(N_OUT),
                .pPOLL_MAX(POLL_MAX)) dut (
      .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .start(start), .busy(busy),
      .done(done), .err(err),
      .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
      .wvalid(wvalid), .wdata(wdata), .wready(wready),
      .arvalid(arvalid), .araddr(araddr), .arready(arready),
      .rvalid(rvalid), .rdata(rdata), .rready(rready),
      .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tdata(ss_tdata), .ss_tready(ss_tready),
      .sm_tvalid(sm_tvalid), .sm_tlast(sm_tlast), .sm_tdata(sm_tdata), .sm_tready(sm_tready)
   );

   job_t jobs [6];
   int   n_chk, n_fail;

   bit            rst_req, start_req, ss_rand, src_rand;
   int            aw_wait, w_wait, hold_left;
   logic [DW-1:0] status_val;

   warr_t         base, src_words, rx_words, sorted_rx, exp_sorted;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] res_q [$];
   int            src_idx, ss_cnt, sm_idx, res_cnt, aw_cnt, w_cnt, aw_hs, w_hs, ar_hs;
   int            done_seen, early, proto_viol, hold_cyc, hold_viol;
   bit            sm_go, r_pend, split_seen, err_at_done;
   logic [AW-1:0] aw_seen_addr, prev_awaddr;
   logic [DW-1:0] w_seen_data, prev_wdata, prev_ss_data;
   bit            prev_aw_stall, prev_w_stall, prev_ss_stall, prev_ss_last;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic warr_t sort_words(input warr_t a);
      warr_t         s;
      logic [DW-1:0] t;
      s = a;
      for (int i = 0; i < N_IN; i++)
         for (int j = 0; j < N_IN - 1 - i; j++)
            if (s[j] > s[j+1]) begin
               t = s[j]; s[j] = s[j+1]; s[j+1] = t;
            end
      return s;
   endfunction

   // One clock: drive slave/source inputs on the falling edge, observe 1 ns later.
   task automatic tick();
      @(negedge axis_clk);
      axis_rst_n = !rst_req;
      start      = start_req;
      awready    = awvalid && (aw_cnt >= aw_wait);
      wready     = wvalid && (w_cnt >= w_wait);
      arready    = arvalid;
      rvalid     = r_pend;
      rdata      = r_pend ? status_val : '0;
      ss_tready  = ss_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      src_valid  = (src_idx < N_IN) && (src_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
      src_data   = (src_idx < N_IN) ? src_words[src_idx] : '0;
      sm_tvalid  = sm_go && (sm_idx < N_OUT);
      sm_tdata   = (sm_idx < N_OUT) ? sorted_rx[sm_idx] : '0;
      sm_tlast   = (sm_idx == N_OUT - 1);
      res_ready  = (hold_left == 0);
      if (sm_tvalid && hold_left > 0) hold_left--;
      #1;
      if (prev_aw_stall && !(awvalid && awaddr == prev_awaddr)) proto_viol++;
      if (prev_w_stall && !(wvalid && wdata == prev_wdata)) proto_viol++;
      if (prev_ss_stall && !(ss_tvalid && ss_tdata == prev_ss_data && ss_tlast == prev_ss_last))
         proto_viol++;
      prev_aw_stall = awvalid && !awready && !rst_req;
      prev_w_stall  = wvalid && !wready && !rst_req;
      prev_ss_stall = ss_tvalid && !ss_tready && !rst_req;
      prev_awaddr   = awaddr;
      prev_wdata    = wdata;
      prev_ss_data  = ss_tdata;
      prev_ss_last  = ss_tlast;
      if (awvalid && awready) begin
         aw_hs++; aw_seen_addr = awaddr; aw_cnt = 0;
      end else if (awvalid) aw_cnt++;
      else aw_cnt = 0;
      if (wvalid && wready) begin
         w_hs++; w_seen_data = wdata; w_cnt = 0;
      end else if (wvalid) w_cnt++;
      else w_cnt = 0;
      if (!awvalid && wvalid) split_seen = 1'b1;
      if ((src_ready || ss_tvalid) && !(aw_hs > 0 && w_hs > 0)) early++;
      if (src_valid && src_ready) begin
         exp_q.push_back(src_data);
         src_idx++;
      end
      if (ss_tvalid && ss_tready) begin
         if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL ss_extra_word: actual=%0h required=none", ss_tdata);
         end else chk("ss_data", ss_tdata, exp_q.pop_front());
         chk("ss_tlast", ss_tlast, (ss_cnt == N_IN - 1));
         if (ss_cnt < N_IN) rx_words[ss_cnt] = ss_tdata;
         ss_cnt++;
         if (ss_cnt == N_IN) begin
            sorted_rx = sort_words(rx_words);
            sm_go     = 1'b1;
         end
      end
      if (sm_tvalid && !res_ready) begin
         hold_cyc++;
         if (sm_tready) hold_viol++;
      end
      if (res_valid && res_ready) begin
         if (res_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL res_extra_word: actual=%0h required=none", res_data);
         end else chk("res_data", res_data, res_q.pop_front());
         res_cnt++;
      end
      if (sm_tvalid && sm_tready) sm_idx++;
      if (rvalid && rready) r_pend = 1'b0;
      if (arvalid && arready) begin
         ar_hs++;
         if (araddr != '0) proto_viol++;
         r_pend = 1'b1;
      end
      if (rst_req) r_pend = 1'b0;
      if (done) begin
         done_seen++;
         err_at_done = err;
      end
   endtask

   task automatic prep(input job_t j, input int row);
      aw_wait = j.aw_wait; w_wait = j.w_wait; ss_rand = j.ss_rand; src_rand = j.src_rand;
      hold_left = j.res_hold; status_val = j.status;
      src_idx = 0; ss_cnt = 0; sm_idx = 0; sm_go = 1'b0; res_cnt = 0;
      aw_cnt = 0; w_cnt = 0; aw_hs = 0; w_hs = 0; ar_hs = 0; done_seen = 0;
      early = 0; proto_viol = 0; hold_cyc = 0; hold_viol = 0;
      split_seen = 1'b0; err_at_done = 1'b0; r_pend = 1'b0;
      aw_seen_addr = '0; w_seen_data = '0;
      exp_q.delete(); res_q.delete();
      for (int i = 0; i < N_IN; i++)
         src_words[i] = (row == 0) ? base[i] : ((DW'(row) << 8) | base[(i + row) % N_IN]);
      exp_sorted = sort_words(src_words);
      for (int i = 0; i < N_OUT; i++) res_q.push_back(exp_sorted[i]);
   endtask

   task automatic run_job(input job_t j, input int row);
      int n;
      prep(j, row);
      start_req = 1'b1;
      tick();
      start_req = 1'b0;
      tick();
      chk("awvalid_after_start", awvalid, 1);
      chk("busy_after_start", busy, 1);
      chk("err_cleared_on_start", err, 0);
      n = 0;
      while (done_seen == 0 && n < 2000) begin
         tick();
         n++;
      end
      chk("job_finished", done_seen, 1);
      tick();
      chk("done_single_cycle", done, 0);
      chk("idle_after_done", busy, 0);
      chk("err_sticky", err, j.exp_err);
      chk("ss_word_count", ss_cnt, N_IN);
      chk("res_word_count", res_cnt, N_OUT);
      chk("aw_count", aw_hs, 1);
      chk("w_count", w_hs, 1);
      chk("aw_addr", aw_seen_addr, 'h8);
      chk("w_data", w_seen_data, 1);
      chk("poll_reads", ar_hs, j.exp_polls);
      chk("err_at_done", err_at_done, j.exp_err);
      chk("aw_w_split", split_seen, j.exp_split);
      chk("push_before_write", early, 0);
      chk("protocol_violations", proto_viol, 0);
      chk("res_hold_cycles", hold_cyc, j.res_hold);
      chk("sm_tready_during_hold", hold_viol, 0);
   endtask

   initial begin
      int n;
      n_chk = 0; n_fail = 0;
      axis_rst_n = 1'b0; start = 1'b0; src_valid = 1'b0; src_data = '0; res_ready = 1'b0;
      awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
      ss_tready = 1'b0; sm_tvalid = 1'b0; sm_tlast = 1'b0; sm_tdata = '0;
      base = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd8, 32'd2, 32'd6, 32'd0, 32'd5, 32'd4};
      //            aw w  ss_rand src_rand hold status polls err   split
      jobs[0] = '{0, 0, 1'b0, 1'b0, 0, 32'h2, 1, 1'b0, 1'b0};
      jobs[1] = '{0, 3, 1'b0, 1'b0, 0, 32'h2, 1, 1'b0, 1'b1};
      jobs[2] = '{0, 0, 1'b1, 1'b1, 0, 32'h2, 1, 1'b0, 1'b0};
      jobs[3] = '{0, 0, 1'b0, 1'b0, 5, 32'h2, 1, 1'b0, 1'b0};
      jobs[4] = '{0, 0, 1'b0, 1'b0, 0, 32'h4, 4, 1'b1, 1'b0};
      jobs[5] = '{2, 2, 1'b1, 1'b0, 3, 32'h6, 1, 1'b0, 1'b0};

      prep(jobs[0], 0);
      src_idx = N_IN;
      rst_req = 1'b1; start_req = 1'b0;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_awvalid", awvalid, 0);
      chk("rst_wvalid", wvalid, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_ss_tvalid", ss_tvalid, 0);
      chk("rst_ss_tlast", ss_tlast, 0);
      chk("rst_awaddr", awaddr, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_ss_tdata", ss_tdata, 0);
      rst_req = 1'b0;
      tick();

      for (int r = 0; r < 6; r++) run_job(jobs[r], r);

      // abort mid-PUSH, then a fresh job must run cleanly
      prep(jobs[0], 0);
      start_req = 1'b1;
      tick();
      start_req = 1'b0;
      n = 0;
      while (ss_cnt < 5 && n < 200) begin
         tick();
         n++;
      end
      chk("mid_push_words", ss_cnt, 5);
      rst_req = 1'b1;
      tick();
      rst_req = 1'b0;
      tick();
      chk("abort_busy", busy, 0);
      chk("abort_awvalid", awvalid, 0);
      chk("abort_wvalid", wvalid, 0);
      chk("abort_arvalid", arvalid, 0);
      chk("abort_ss_tvalid", ss_tvalid, 0);
      chk("abort_src_ready", src_ready, 0);
      chk("abort_res_valid", res_valid, 0);
      chk("abort_done", done, 0);
      tick();
      run_job(jobs[0], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
